// File: rtl/nn_pkg.sv
// Shared types and elaboration helpers for the neuron datapath blocks.
package nn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter width for a modulus n; never below 1 so a single-weight neuron still gets a register.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with enable; wrap flags the enabled step from MODULUS-1 back to 0.
module wrap_counter #(
  parameter int WIDTH   = 1,
  parameter int MODULUS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  cnt <= '0;
    else if (en) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/weight_seq_ctrl.sv
// Per-neuron weight memory sequencer: steers matching config writes into the memory and
// pairs each activation with its weight for the MAC, one cycle after the read.
module weight_seq_ctrl
  import nn_pkg::*;
#(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int layerNo      = 1,
  parameter int neuronNo     = 0,
  parameter int preloaded    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  input  logic [31:0]             cfg_layer,
  input  logic [31:0]             cfg_neuron,
  input  logic [dataWidth-1:0]    cfg_data,
  output logic                    cfg_ready,
  input  logic                    x_valid,
  input  logic [dataWidth-1:0]    x_in,
  output logic                    mem_wen,
  output logic [addressWidth-1:0] mem_wadd,
  output logic [dataWidth-1:0]    mem_win,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_wout,
  output logic                    mac_valid,
  output logic [dataWidth-1:0]    mac_x,
  output logic [dataWidth-1:0]    mac_w,
  output logic                    mac_last,
  output logic                    weights_loaded,
  output logic                    load_done
);

  localparam int             CW   = clog2(numWeight);
  localparam logic [CW-1:0]  LAST = CW'(numWeight - 1);
  localparam bit             MULTI = (numWeight > 1);

  state_e                 state;
  logic [CW-1:0]          rd_cnt, wr_cnt;
  logic                   rd_wrap, wr_wrap;
  logic                   cfg_acc, cfg_hit;
  logic [dataWidth-1:0]   x_d;
  logic                   valid_d, last_d;

  // Activations have no backpressure, so config yields to them and to any read run in flight.
  assign cfg_ready = (state == IDLE) && !x_valid;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign cfg_hit   = cfg_acc && (cfg_layer == 32'(layerNo)) && (cfg_neuron == 32'(neuronNo));

  wrap_counter #(.WIDTH(CW), .MODULUS(numWeight)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (x_valid),
    .cnt   (rd_cnt),
    .wrap  (rd_wrap)
  );

  wrap_counter #(.WIDTH(CW), .MODULUS(numWeight)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cfg_hit),
    .cnt   (wr_cnt),
    .wrap  (wr_wrap)
  );

  assign mem_ren  = x_valid;
  assign mem_radd = addressWidth'(rd_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (MULTI && x_valid && (rd_cnt == '0)) state <= RUN;
        RUN:     if (rd_wrap) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wen        <= 1'b0;
      mem_wadd       <= '0;
      mem_win        <= '0;
      load_done      <= 1'b0;
      weights_loaded <= (preloaded != 0);
    end else begin
      mem_wen   <= cfg_hit;
      load_done <= wr_wrap;
      if (cfg_hit) begin
        mem_wadd <= addressWidth'(wr_cnt);
        mem_win  <= cfg_data;
      end
      if (wr_wrap) weights_loaded <= 1'b1;
    end
  end

  // Memory read data lands one cycle after mem_ren; delay x and its flags to meet it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_d     <= '0;
      valid_d <= 1'b0;
      last_d  <= 1'b0;
    end else begin
      x_d     <= x_in;
      valid_d <= x_valid;
      last_d  <= (rd_cnt == LAST);
    end
  end

  assign mac_valid = valid_d;
  assign mac_x     = x_d;
  assign mac_w     = mem_wout;
  assign mac_last  = last_d && valid_d;

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Directed bench: a 4-weight neuron against a small memory model, plus a preloaded single-weight neuron.
module tb_weight_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // 4-weight, layer 1 / neuron 2
  logic        cfg_valid, cfg_ready, x_valid;
  logic [31:0] cfg_layer, cfg_neuron;
  logic [15:0] cfg_data, x_in, mem_win, mem_wout, mac_x, mac_w;
  logic [3:0]  mem_wadd, mem_radd;
  logic        mem_wen, mem_ren, mac_valid, mac_last, weights_loaded, load_done;

  // 1-weight, preloaded
  logic        cfg_ready2, x2_valid, mem_wen2, mem_ren2, mac_valid2, mac_last2, weights_loaded2, load_done2;
  logic [15:0] x2_in, mem_win2, mac_x2, mac_w2;
  logic [15:0] mem_wout2 = 16'h0abc;
  logic [0:0]  mem_wadd2, mem_radd2;

  logic [15:0] mem [0:15];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) mem[mem_wadd] <= mem_win;
    if (mem_ren) mem_wout <= mem[mem_radd];
  end

  weight_seq_ctrl #(.numWeight(4), .addressWidth(4), .dataWidth(16), .layerNo(1), .neuronNo(2),
                    .preloaded(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .x_valid(x_valid), .x_in(x_in), .mem_wen(mem_wen),
    .mem_wadd(mem_wadd), .mem_win(mem_win), .mem_ren(mem_ren), .mem_radd(mem_radd),
    .mem_wout(mem_wout), .mac_valid(mac_valid), .mac_x(mac_x), .mac_w(mac_w), .mac_last(mac_last),
    .weights_loaded(weights_loaded), .load_done(load_done)
  );

  weight_seq_ctrl #(.numWeight(1), .addressWidth(1), .dataWidth(16), .layerNo(1), .neuronNo(0),
                    .preloaded(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(1'b0), .cfg_layer(32'd1), .cfg_neuron(32'd0),
    .cfg_data(16'h0000), .cfg_ready(cfg_ready2), .x_valid(x2_valid), .x_in(x2_in), .mem_wen(mem_wen2),
    .mem_wadd(mem_wadd2), .mem_win(mem_win2), .mem_ren(mem_ren2), .mem_radd(mem_radd2),
    .mem_wout(mem_wout2), .mac_valid(mac_valid2), .mac_x(mac_x2), .mac_w(mac_w2), .mac_last(mac_last2),
    .weights_loaded(weights_loaded2), .load_done(load_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_layer = 32'd1; cfg_neuron = 32'd2; cfg_data = '0;
    x_valid = 1'b0; x_in = '0; x2_valid = 1'b0; x2_in = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_weights_loaded", weights_loaded, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_preloaded", weights_loaded2, 1);
    @(negedge clk); rst_n = 1'b1;

    // Full weight load
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_neuron = 32'd2; cfg_data = 16'(16'h0011 * (i + 1));
      #1 chk("ld_ready", cfg_ready, 1);
      @(posedge clk); #1;
      chk("ld_wen", mem_wen, 1);
      chk("ld_wadd", mem_wadd, i);
      chk("ld_win", mem_win, 16'h0011 * (i + 1));
      chk("ld_done", load_done, (i == 3));
      chk("ld_loaded", weights_loaded, (i == 3));
    end
    @(negedge clk); cfg_valid = 1'b0;
    @(posedge clk); #1;
    chk("ld_idle_wen", mem_wen, 0);
    chk("ld_done_pulse", load_done, 0);
    chk("ld_sticky", weights_loaded, 1);

    // Non-matching beat consumed without a write, write pointer unchanged
    @(negedge clk); cfg_valid = 1'b1; cfg_neuron = 32'd3; cfg_data = 16'hdead;
    #1 chk("nm_ready", cfg_ready, 1);
    @(posedge clk); #1 chk("nm_wen", mem_wen, 0);
    @(negedge clk); cfg_neuron = 32'd2; cfg_data = 16'h0011;
    @(posedge clk); #1;
    chk("nm_next_wen", mem_wen, 1);
    chk("nm_next_wadd", mem_wadd, 0);
    chk("nm_next_done", load_done, 0);
    @(negedge clk); cfg_valid = 1'b0;

    // Back-to-back activation stream
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); x_valid = 1'b1; x_in = 16'(i + 1);
      #1;
      chk("st_ren", mem_ren, 1);
      chk("st_radd", mem_radd, i);
      chk("st_cfg_ready", cfg_ready, 0);
      @(posedge clk); #1;
      chk("st_mac_valid", mac_valid, 1);
      chk("st_mac_x", mac_x, i + 1);
      chk("st_mac_w", mac_w, 16'h0011 * (i + 1));
      chk("st_mac_last", mac_last, (i == 3));
    end
    @(negedge clk); x_valid = 1'b0;
    #1 chk("st_end_idle", cfg_ready, 1);
    @(posedge clk); #1;
    chk("st_gap_valid", mac_valid, 0);
    chk("st_gap_last", mac_last, 0);

    // Same-cycle cfg/x conflict: activation wins, cfg held until the run ends
    @(negedge clk); cfg_valid = 1'b1; cfg_neuron = 32'd2; cfg_data = 16'h0022; x_valid = 1'b1; x_in = 16'd5;
    #1 chk("cf_ready", cfg_ready, 0);
    @(posedge clk); #1;
    chk("cf_wen", mem_wen, 0);
    chk("cf_mac_x", mac_x, 5);
    chk("cf_mac_w", mac_w, 16'h0011);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); x_in = 16'(5 + i);
      #1 chk("cf_run_ready", cfg_ready, 0);
      @(posedge clk); #1;
      chk("cf_run_wen", mem_wen, 0);
      chk("cf_run_w", mac_w, 16'h0011 * (i + 1));
      chk("cf_run_last", mac_last, (i == 3));
    end
    @(negedge clk); x_valid = 1'b0;
    #1 chk("cf_accept_ready", cfg_ready, 1);
    @(posedge clk); #1;
    chk("cf_accept_wen", mem_wen, 1);
    chk("cf_accept_wadd", mem_wadd, 1);
    chk("cf_accept_win", mem_win, 16'h0022);
    @(negedge clk); cfg_valid = 1'b0;

    // Partial run, gap, then reset aborts it
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); x_valid = 1'b1; x_in = 16'(7 + i);
      #1 chk("ab_radd", mem_radd, i);
    end
    @(negedge clk); x_valid = 1'b0;
    #1 chk("ab_gap_ready", cfg_ready, 0);
    @(posedge clk); #1 chk("ab_gap_valid", mac_valid, 0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("ab_rst_loaded", weights_loaded, 0);
    chk("ab_rst_ready", cfg_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); x_valid = 1'b1; x_in = 16'(9 + i);
      #1 chk("rs_radd", mem_radd, i);
      @(posedge clk); #1;
      chk("rs_mac_w", mac_w, 16'h0011 * (i + 1));
      chk("rs_mac_last", mac_last, (i == 3));
    end
    @(negedge clk); x_valid = 1'b0;

    // Single-weight, preloaded neuron: every beat is last, state never leaves IDLE
    chk("p1_loaded", weights_loaded2, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); x2_valid = 1'b1; x2_in = 16'(16'h0055 + i);
      #1;
      chk("p1_radd", mem_radd2, 0);
      chk("p1_ren", mem_ren2, 1);
      @(posedge clk); #1;
      chk("p1_mac_valid", mac_valid2, 1);
      chk("p1_mac_x", mac_x2, 16'h0055 + i);
      chk("p1_mac_w", mac_w2, 16'h0abc);
      chk("p1_mac_last", mac_last2, 1);
    end
    @(negedge clk); x2_valid = 1'b0;
    #1 chk("p1_idle", cfg_ready2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
